sparse_chunk_encoder: RTL and testbench

Upstream feeder for the compute unit. Accepts dense activation or filter words, one BUS_SIZE-byte word per beat. Produces the sparsemap plus left-packed nonzero-byte bus that the compute unit's ifm/filter write port consumes over a valid/ready handshake. Tracks chunk boundaries (MEM_SIZE bytes per chunk) and flags the last beat of each chunk. One instance sits per operand stream (ifm and filter).

---
 rtl/sparse_chunk_encoder.sv | 165 ++++++++++++++++
 tb/tb_sparse_chunk_encoder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sparse_chunk_encoder.sv
// Dense-to-sparse word encoder with a 2-entry skid (output register + skid register).
// Emits sparsemap, left-packed nonzero bytes and popcount, and tracks chunk boundaries.
module sparse_chunk_encoder #(
  parameter int MEM_SIZE = 128,
  parameter int BUS_SIZE = 8
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [BUS_SIZE*8-1:0]                  dense_dat_i,
  input  logic                                   dense_val_i,
  output logic                                   dense_rdy_o,
  output logic [BUS_SIZE-1:0]                    sparsemap_o,
  output logic [BUS_SIZE*8-1:0]                  nonzero_dat_o,
  output logic [$clog2(BUS_SIZE+1)-1:0]          nonzero_cnt_o,
  output logic                                   wr_valid_o,
  input  logic                                   wr_ready_i,
  output logic                                   chunk_last_o,
  output logic                                   chunk_done_o,
  output logic [$clog2(MEM_SIZE/BUS_SIZE)-1:0]   beat_cnt_o
);

  localparam int WORDS_PER_CHUNK = MEM_SIZE / BUS_SIZE;
  localparam int DW = BUS_SIZE * 8;
  localparam int CW = $clog2(BUS_SIZE + 1);
  localparam int BW = $clog2(WORDS_PER_CHUNK);

  function automatic logic [BUS_SIZE-1:0] byte_map(input logic [DW-1:0] d);
    logic [BUS_SIZE-1:0] m;
    for (int k = 0; k < BUS_SIZE; k++) m[k] = |d[8*k +: 8];
    return m;
  endfunction

  function automatic logic [DW-1:0] pack_bytes(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    int j;
    r = '0;
    j = 0;
    for (int k = 0; k < BUS_SIZE; k++) begin
      if (|d[8*k +: 8]) begin
        r[8*j +: 8] = d[8*k +: 8];
        j++;
      end
    end
    return r;
  endfunction

  function automatic logic [CW-1:0] popcount(input logic [BUS_SIZE-1:0] m);
    logic [CW-1:0] c;
    c = '0;
    for (int k = 0; k < BUS_SIZE; k++) c = c + CW'(m[k]);
    return c;
  endfunction

  logic [BUS_SIZE-1:0] enc_map;
  logic [DW-1:0]       enc_dat;
  logic [CW-1:0]       enc_cnt;
  logic                enc_last;

  logic                out_vld_q, out_vld_d, out_last_q, out_last_d;
  logic [BUS_SIZE-1:0] out_map_q, out_map_d;
  logic [DW-1:0]       out_dat_q, out_dat_d;
  logic [CW-1:0]       out_cnt_q, out_cnt_d;
  logic                skid_vld_q, skid_vld_d, skid_last_q, skid_last_d;
  logic [BUS_SIZE-1:0] skid_map_q, skid_map_d;
  logic [DW-1:0]       skid_dat_q, skid_dat_d;
  logic [CW-1:0]       skid_cnt_q, skid_cnt_d;
  logic                rdy_q, rdy_d, done_q, done_d;
  logic [BW-1:0]       beat_q, beat_d;
  logic                accept, out_fire, out_free;

  assign accept   = dense_val_i && rdy_q;
  assign out_fire = out_vld_q && wr_ready_i;
  assign out_free = !out_vld_q || wr_ready_i;

  assign enc_map  = byte_map(dense_dat_i);
  assign enc_dat  = pack_bytes(dense_dat_i);
  assign enc_cnt  = popcount(enc_map);
  assign enc_last = (beat_q == BW'(WORDS_PER_CHUNK - 1));

  always_comb begin
    out_vld_d   = out_vld_q;
    out_map_d   = out_map_q;
    out_dat_d   = out_dat_q;
    out_cnt_d   = out_cnt_q;
    out_last_d  = out_last_q;
    skid_vld_d  = skid_vld_q;
    skid_map_d  = skid_map_q;
    skid_dat_d  = skid_dat_q;
    skid_cnt_d  = skid_cnt_q;
    skid_last_d = skid_last_q;
    beat_d      = beat_q;
    done_d      = out_fire && out_last_q;

    // Skid register is drained first; input only bypasses it when it is empty.
    if (out_free) begin
      if (skid_vld_q) begin
        out_vld_d  = 1'b1;
        out_map_d  = skid_map_q;
        out_dat_d  = skid_dat_q;
        out_cnt_d  = skid_cnt_q;
        out_last_d = skid_last_q;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        out_vld_d  = 1'b1;
        out_map_d  = enc_map;
        out_dat_d  = enc_dat;
        out_cnt_d  = enc_cnt;
        out_last_d = enc_last;
      end else begin
        out_vld_d  = 1'b0;
      end
    end else if (accept) begin
      skid_vld_d  = 1'b1;
      skid_map_d  = enc_map;
      skid_dat_d  = enc_dat;
      skid_cnt_d  = enc_cnt;
      skid_last_d = enc_last;
    end

    if (accept) beat_d = enc_last ? '0 : beat_q + BW'(1);
    rdy_d = !skid_vld_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_vld_q   <= 1'b0;
      out_map_q   <= '0;
      out_dat_q   <= '0;
      out_cnt_q   <= '0;
      out_last_q  <= 1'b0;
      skid_vld_q  <= 1'b0;
      skid_map_q  <= '0;
      skid_dat_q  <= '0;
      skid_cnt_q  <= '0;
      skid_last_q <= 1'b0;
      rdy_q       <= 1'b0;
      done_q      <= 1'b0;
      beat_q      <= '0;
    end else begin
      out_vld_q   <= out_vld_d;
      out_map_q   <= out_map_d;
      out_dat_q   <= out_dat_d;
      out_cnt_q   <= out_cnt_d;
      out_last_q  <= out_last_d;
      skid_vld_q  <= skid_vld_d;
      skid_map_q  <= skid_map_d;
      skid_dat_q  <= skid_dat_d;
      skid_cnt_q  <= skid_cnt_d;
      skid_last_q <= skid_last_d;
      rdy_q       <= rdy_d;
      done_q      <= done_d;
      beat_q      <= beat_d;
    end
  end

  assign dense_rdy_o   = rdy_q;
  assign wr_valid_o    = out_vld_q;
  assign sparsemap_o   = out_map_q;
  assign nonzero_dat_o = out_dat_q;
  assign nonzero_cnt_o = out_cnt_q;
  assign chunk_last_o  = out_last_q;
  assign chunk_done_o  = done_q;
  assign beat_cnt_o    = beat_q;

endmodule

// File: tb/tb_sparse_chunk_encoder.sv
// Directed bench for sparse_chunk_encoder: encoding table, streaming, skid back-pressure,
// chunk boundary tracking and mid-chunk reset.
module tb_sparse_chunk_encoder;

  logic        clk, rst;
  logic [63:0] dense_dat;
  logic        dense_val, dense_rdy;
  logic [7:0]  sparsemap;
  logic [63:0] nonzero_dat;
  logic [3:0]  nonzero_cnt;
  logic        wr_valid, wr_ready;
  logic        chunk_last, chunk_done;
  logic [3:0]  beat_cnt;

  int n_chk = 0;
  int n_fail = 0;

  sparse_chunk_encoder #(.MEM_SIZE(128), .BUS_SIZE(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .dense_dat_i(dense_dat), .dense_val_i(dense_val), .dense_rdy_o(dense_rdy),
    .sparsemap_o(sparsemap), .nonzero_dat_o(nonzero_dat), .nonzero_cnt_o(nonzero_cnt),
    .wr_valid_o(wr_valid), .wr_ready_i(wr_ready),
    .chunk_last_o(chunk_last), .chunk_done_o(chunk_done), .beat_cnt_o(beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] dense;
    logic [7:0]  map;
    logic [63:0] dat;
    logic [3:0]  cnt;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    dense_val = 1'b0;
    dense_dat = '0;
    step();
    check("rst_rdy", 64'(dense_rdy), 64'd0);
    check("rst_valid", 64'(wr_valid), 64'd0);
    check("rst_beat", 64'(beat_cnt), 64'd0);
    check("rst_done", 64'(chunk_done), 64'd0);
    check("rst_map", 64'(sparsemap), 64'd0);
    rst = 1'b0;
    step();
    check("rel_rdy", 64'(dense_rdy), 64'd1);
  endtask

  initial begin
    vecs[0] = '{64'h0011000022003300, 8'h4A, 64'h0000000000112233, 4'd3};
    vecs[1] = '{64'h0000000000000000, 8'h00, 64'h0000000000000000, 4'd0};
    vecs[2] = '{64'h0807060504030201, 8'hFF, 64'h0807060504030201, 4'd8};
    vecs[3] = '{64'h00000000000000FF, 8'h01, 64'h00000000000000FF, 4'd1};
    vecs[4] = '{64'hFF00000000000000, 8'h80, 64'h00000000000000FF, 4'd1};
    vecs[5] = '{64'h0100010001000100, 8'hAA, 64'h0000000001010101, 4'd4};
    vecs[6] = '{64'h00AB00CD00EF0012, 8'h55, 64'h00000000ABCDEF12, 4'd4};

    rst = 1'b1;
    dense_val = 1'b0;
    dense_dat = '0;
    wr_ready = 1'b1;
    step();
    do_reset();

    // Encoding table: one accept per vector, output one edge later, then drain.
    for (int i = 0; i < 7; i++) begin
      dense_dat = vecs[i].dense;
      dense_val = 1'b1;
      step();
      dense_val = 1'b0;
      check($sformatf("tbl%0d_valid", i), 64'(wr_valid), 64'd1);
      check($sformatf("tbl%0d_map", i), 64'(sparsemap), 64'(vecs[i].map));
      check($sformatf("tbl%0d_dat", i), nonzero_dat, vecs[i].dat);
      check($sformatf("tbl%0d_cnt", i), 64'(nonzero_cnt), 64'(vecs[i].cnt));
      check($sformatf("tbl%0d_beat", i), 64'(beat_cnt), 64'(i + 1));
      step();
      check($sformatf("tbl%0d_drain", i), 64'(wr_valid), 64'd0);
    end

    // Full-throughput stream of 6 words.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      dense_dat = 64'(i + 1) << (8 * i);
      dense_val = 1'b1;
      step();
      check($sformatf("str%0d_rdy", i), 64'(dense_rdy), 64'd1);
      check($sformatf("str%0d_valid", i), 64'(wr_valid), 64'd1);
      check($sformatf("str%0d_dat", i), nonzero_dat, 64'(i + 1));
      check($sformatf("str%0d_map", i), 64'(sparsemap), 64'd1 << i);
    end
    dense_val = 1'b0;
    step();
    check("str_end_valid", 64'(wr_valid), 64'd0);

    // Back-pressure: two words absorbed, third held off, outputs stable.
    do_reset();
    wr_ready = 1'b0;
    dense_dat = 64'h0A;
    dense_val = 1'b1;
    step();
    check("bp_a_valid", 64'(wr_valid), 64'd1);
    check("bp_a_rdy", 64'(dense_rdy), 64'd1);
    dense_dat = 64'h0B00;
    step();
    check("bp_b_rdy", 64'(dense_rdy), 64'd0);
    dense_dat = 64'h0C0000;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("bp_hold%0d_rdy", i), 64'(dense_rdy), 64'd0);
      check($sformatf("bp_hold%0d_dat", i), nonzero_dat, 64'h0A);
      check($sformatf("bp_hold%0d_map", i), 64'(sparsemap), 64'h01);
      check($sformatf("bp_hold%0d_valid", i), 64'(wr_valid), 64'd1);
      check($sformatf("bp_hold%0d_beat", i), 64'(beat_cnt), 64'd2);
    end
    dense_val = 1'b0;
    wr_ready = 1'b1;
    step();
    check("bp_b_valid", 64'(wr_valid), 64'd1);
    check("bp_b_dat", nonzero_dat, 64'h0B);
    check("bp_b_map", 64'(sparsemap), 64'h02);
    check("bp_rdy_back", 64'(dense_rdy), 64'd1);
    step();
    check("bp_empty", 64'(wr_valid), 64'd0);

    // Chunk boundary across 17 beats.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      dense_dat = 64'(i + 1);
      dense_val = 1'b1;
      step();
      check($sformatf("ch%0d_last", i), 64'(chunk_last), 64'(i == 15));
      check($sformatf("ch%0d_beat", i), 64'((i + 1) % 16), 64'(beat_cnt));
      check($sformatf("ch%0d_done", i), 64'(chunk_done), 64'(i == 16));
      check($sformatf("ch%0d_dat", i), nonzero_dat, 64'(i + 1));
    end
    dense_val = 1'b0;
    step();
    check("ch_done_pulse_end", 64'(chunk_done), 64'd0);

    // Mid-chunk asynchronous reset with a word parked in the skid.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      dense_dat = 64'(i + 1);
      dense_val = 1'b1;
      if (i == 4) wr_ready = 1'b0;
      step();
    end
    dense_val = 1'b0;
    check("mr_pre_beat", 64'(beat_cnt), 64'd5);
    check("mr_pre_rdy", 64'(dense_rdy), 64'd0);
    check("mr_pre_valid", 64'(wr_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("mr_async_valid", 64'(wr_valid), 64'd0);
    check("mr_async_beat", 64'(beat_cnt), 64'd0);
    check("mr_async_rdy", 64'(dense_rdy), 64'd0);
    step();
    rst = 1'b0;
    wr_ready = 1'b1;
    step();
    check("mr_rel_rdy", 64'(dense_rdy), 64'd1);
    check("mr_rel_valid", 64'(wr_valid), 64'd0);
    for (int i = 0; i < 16; i++) begin
      dense_dat = 64'h10 + 64'(i);
      dense_val = 1'b1;
      step();
      check($sformatf("mr%0d_last", i), 64'(chunk_last), 64'(i == 15));
    end
    dense_val = 1'b0;
    step();
    check("mr_done", 64'(chunk_done), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
